// File: rtl/acsi_pkg.sv
// acsi_pkg: shared constants, assembler state type and opcode length decode for the ACSI command queue
package acsi_pkg;
    localparam logic [4:0] ICD_ESC = 5'h1F;
    localparam int STATUS_SEL_HEAD_INFO = 16;
    localparam int STATUS_SEL_QSTAT = 17;

    typedef enum logic {IDLE, COLLECT} asm_state_t;

    // Command length is fixed by the opcode group in bits [7:5].
    function automatic logic [4:0] cmd_len(input logic [7:0] op);
        return op[7:5] == 3'd0 ? 5'd6
             : (op[7:5] == 3'd1 || op[7:5] == 3'd2) ? 5'd10
             : op[7:5] == 3'd4 ? 5'd16
             : op[7:5] == 3'd5 ? 5'd12
             : 5'd6;
    endfunction
endpackage

// File: rtl/acsi_cmd_fifo.sv
// acsi_cmd_fifo: queue of completed ACSI commands (target, length, bytes) with head readout
// Ports: clk, reset (async, active high); push with push_target/push_len/push_bytes;
// pop drops the head; full/empty/count status; head_target/head_len/head_bytes show the head.
module acsi_cmd_fifo #(
    parameter int DEPTH = 2,
    parameter int NB = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [2:0]      push_target,
    input  logic [4:0]      push_len,
    input  logic [NB*8-1:0] push_bytes,
    output logic            full,
    output logic            empty,
    output logic [3:0]      count,
    output logic [2:0]      head_target,
    output logic [4:0]      head_len,
    output logic [NB*8-1:0] head_bytes
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [2:0]      tq [DEPTH];
    logic [4:0]      lq [DEPTH];
    logic [NB*8-1:0] bq [DEPTH];
    logic [AW-1:0]   wp, rp;

    assign full = count == 4'(DEPTH);
    assign empty = count == 4'd0;
    assign head_target = tq[rp];
    assign head_len = lq[rp];
    assign head_bytes = bq[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= 4'd0;
        end else begin
            if (push) wp <= wp == AW'(DEPTH - 1) ? '0 : wp + 1'b1;
            if (pop) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + 1'b1;
            count <= count + 4'(push) - 4'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tq[wp] <= push_target;
            lq[wp] <= push_len;
            bq[wp] <= push_bytes;
        end
    end
endmodule

// File: rtl/acsi_cmd_queue.sv
// acsi_cmd_queue: ACSI command assembler with per-target enables, inter-byte timeout and a completed-command queue
// Ports: clk, reset (async, active high); enable per target; dma_ack/dma_nak drain the queue head;
// dma_status is returned on cpu_dout; status_sel/status_byte read head bytes, head info and queue status;
// cpu_addr/cpu_sel/cpu_rw/cpu_din form the CPU bus; irq goes to the MFP; busy = queue non-empty.
module acsi_cmd_queue
    import acsi_pkg::*;
#(
    parameter int NUM_TARGETS = 8,
    parameter int MAX_CMD_BYTES = 16,
    parameter int QUEUE_DEPTH = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_TARGETS-1:0] enable,
    input  logic                   dma_ack,
    input  logic                   dma_nak,
    input  logic [7:0]             dma_status,
    input  logic [4:0]             status_sel,
    output logic [7:0]             status_byte,
    input  logic [1:0]             cpu_addr,
    input  logic                   cpu_sel,
    input  logic                   cpu_rw,
    input  logic [7:0]             cpu_din,
    output logic [7:0]             cpu_dout,
    output logic                   irq,
    output logic                   busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    asm_state_t                 state;
    logic [2:0]                 target, head_target;
    logic [4:0]                 idx, len_r, cur_len, head_len;
    logic                       rej_r, cur_rej;
    logic [MAX_CMD_BYTES*8-1:0] cmd_bytes, push_bytes, head_bytes;
    logic [TW-1:0]              timer;
    logic [7:0]                 en8;
    logic [3:0]                 count;
    logic overflow, tout_seen, full, empty, push, pop;
    logic wr, wr_first, wr_next, is_final, accept, irq_set, tout, stat_clr;
    logic unused_addr;

    assign unused_addr = cpu_addr[1];
    assign en8 = 8'(enable);
    assign wr = cpu_sel && !cpu_rw;
    assign wr_first = wr && !cpu_addr[0];
    assign wr_next = wr && cpu_addr[0] && state == COLLECT;
    // Index 0 is only reached after an ICD escape: that byte is the opcode and fixes the length.
    assign cur_len = idx == 5'd0 ? cmd_len(cpu_din) : len_r;
    assign cur_rej = idx == 5'd0 ? cur_len > 5'(MAX_CMD_BYTES) : rej_r;
    assign is_final = idx == cur_len - 5'd1;
    assign accept = wr_next && is_final && en8[target] && !cur_rej;
    assign pop = (dma_ack || dma_nak) && !empty;
    assign push = accept && (!full || pop);
    assign irq_set = (wr_first && en8[cpu_din[7:5]])
                  || (wr_next && !is_final && en8[target] && !cur_rej)
                  || (dma_ack && !empty);
    assign tout = state == COLLECT && !wr && timer == TW'(TIMEOUT_CYCLES);
    assign stat_clr = dma_nak && empty && status_sel == 5'(STATUS_SEL_QSTAT);
    assign busy = !empty;
    assign cpu_dout = dma_status;

    always_comb begin
        push_bytes = cmd_bytes;
        if (int'(idx) < MAX_CMD_BYTES) push_bytes[{idx[3:0], 3'b000} +: 8] = cpu_din;
    end

    assign status_byte = status_sel == 5'(STATUS_SEL_QSTAT) ? {count, 1'b0, tout_seen, overflow, busy}
                       : empty ? 8'h00
                       : status_sel == 5'(STATUS_SEL_HEAD_INFO) ? {head_target, head_len - 5'd1}
                       : int'(status_sel) < MAX_CMD_BYTES ? head_bytes[{status_sel[3:0], 3'b000} +: 8]
                       : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            target <= 3'd0;
            idx <= 5'd0;
            len_r <= 5'd0;
            rej_r <= 1'b0;
            cmd_bytes <= '0;
            timer <= '0;
            irq <= 1'b0;
            overflow <= 1'b0;
            tout_seen <= 1'b0;
        end else begin
            timer <= (wr || state == IDLE) ? '0 : timer + 1'b1;
            if (wr_first) begin
                state <= COLLECT;
                target <= cpu_din[7:5];
                idx <= cpu_din[4:0] == ICD_ESC ? 5'd0 : 5'd1;
                len_r <= cmd_len({3'b000, cpu_din[4:0]});
                rej_r <= 1'b0;
                cmd_bytes[7:0] <= {3'b000, cpu_din[4:0]};
            end else if (wr_next) begin
                cmd_bytes <= push_bytes;
                idx <= idx + 5'd1;
                len_r <= cur_len;
                rej_r <= cur_rej;
                if (is_final) state <= IDLE;
            end else if (tout) begin
                state <= IDLE;
            end
            if (irq_set) irq <= 1'b1;
            else if (cpu_sel) irq <= 1'b0;
            if (accept && full && !pop) overflow <= 1'b1;
            else if (stat_clr) overflow <= 1'b0;
            if (tout) tout_seen <= 1'b1;
            else if (stat_clr) tout_seen <= 1'b0;
        end
    end

    acsi_cmd_fifo #(.DEPTH(QUEUE_DEPTH), .NB(MAX_CMD_BYTES)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .push_target (target),
        .push_len    (cur_len),
        .push_bytes  (push_bytes),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .head_target (head_target),
        .head_len    (head_len),
        .head_bytes  (head_bytes)
    );
endmodule

// File: tb/tb_acsi_cmd_queue.sv
// tb_acsi_cmd_queue: table-driven CPU write vectors plus a command scoreboard drained through the status readback
module tb_acsi_cmd_queue;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       reset, dma_ack, dma_nak, cpu_sel, cpu_rw, irq, busy;
    logic [7:0] enable, dma_status, status_byte, cpu_din, cpu_dout;
    logic [4:0] status_sel;
    logic [1:0] cpu_addr;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        logic       a0;
        logic [7:0] din;
        logic       chk_irq;
        logic       exp_irq;
        logic       exp_push;
        logic [7:0] exp_info;
        logic       ack;
    } vec_t;

    typedef struct {
        logic [7:0]       info;
        logic [15:0][7:0] b;
        int               n;
    } cmd_t;

    vec_t             vecs[$];
    cmd_t             exp_q[$];
    logic [15:0][7:0] acc;
    int               acc_n;

    acsi_cmd_queue #(
        .NUM_TARGETS(8), .MAX_CMD_BYTES(12), .QUEUE_DEPTH(2), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .dma_ack(dma_ack), .dma_nak(dma_nak),
        .dma_status(dma_status), .status_sel(status_sel), .status_byte(status_byte),
        .cpu_addr(cpu_addr), .cpu_sel(cpu_sel), .cpu_rw(cpu_rw), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .irq(irq), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic a0, input logic [7:0] din, input logic chk, input logic ei,
                       input logic ep = 1'b0, input logic [7:0] info = 8'h00, input logic ack = 1'b0);
        vec_t v;
        v.a0 = a0; v.din = din; v.chk_irq = chk; v.exp_irq = ei;
        v.exp_push = ep; v.exp_info = info; v.ack = ack;
        vecs.push_back(v);
    endtask

    task automatic rd(input logic [4:0] s, output logic [7:0] r);
        status_sel = s;
        #1;
        r = status_byte;
    endtask

    task automatic wr(input logic a0, input logic [7:0] d, input logic ack = 1'b0);
        @(negedge clk);
        cpu_sel = 1'b1; cpu_rw = 1'b0; cpu_addr = {1'b0, a0}; cpu_din = d; dma_ack = ack;
        @(posedge clk);
        #1;
        cpu_sel = 1'b0; dma_ack = 1'b0;
    endtask

    task automatic check_head();
        cmd_t e;
        logic [7:0] r;
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL head: scoreboard empty, nothing expected at queue head");
            return;
        end
        e = exp_q.pop_front();
        rd(5'd16, r);
        check("head info", r, e.info);
        for (int i = 0; i < e.n; i++) begin
            rd(5'(i), r);
            check($sformatf("head byte %0d", i), r, e.b[i]);
        end
        status_sel = 5'd0;
    endtask

    task automatic drain(input logic ack, input logic exp_irq);
        check_head();
        @(negedge clk);
        dma_ack = ack; dma_nak = !ack;
        @(posedge clk);
        #1;
        dma_ack = 1'b0; dma_nak = 1'b0;
        check(ack ? "ack irq" : "nak irq", 8'(irq), 8'(exp_irq));
        check("drain busy", 8'(busy), 8'(exp_q.size() != 0));
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            vec_t v;
            cmd_t c;
            v = vecs[i];
            if (v.ack) check_head();
            if (!v.a0) begin
                acc_n = 0;
                if (v.din[4:0] != 5'h1F) begin
                    acc[0] = {3'b000, v.din[4:0]};
                    acc_n = 1;
                end
            end else if (acc_n < 16) begin
                acc[acc_n] = v.din;
                acc_n++;
            end
            wr(v.a0, v.din, v.ack);
            if (v.chk_irq) check($sformatf("irq vec %0d", i), 8'(irq), 8'(v.exp_irq));
            if (v.exp_push) begin
                c.info = v.exp_info; c.b = acc; c.n = acc_n;
                exp_q.push_back(c);
            end
        end
    endtask

    initial begin
        logic [7:0] r;
        reset = 1'b1; enable = 8'hFB; dma_ack = 1'b0; dma_nak = 1'b0; dma_status = 8'hA5;
        status_sel = 5'd0; cpu_addr = 2'd0; cpu_sel = 1'b0; cpu_rw = 1'b0; cpu_din = 8'h00;
        acc = '0; acc_n = 0;

        // 0..16: target 1 group-0 command, then ICD opcode 0x28 for target 0
        add(0, 8'h20, 1, 1);
        for (int i = 1; i <= 4; i++) add(1, 8'(i), 1, 1);
        add(1, 8'h05, 1, 0, 1, 8'h25);
        add(0, 8'h1F, 1, 1);
        add(1, 8'h28, 1, 1);
        for (int i = 1; i <= 8; i++) add(1, 8'h10 + 8'(i), 1, 1);
        add(1, 8'h19, 1, 0, 1, 8'h09);
        // 17..22: final byte lands with dma_ack on a full queue
        add(0, 8'h21, 1, 1);
        for (int i = 1; i <= 4; i++) add(1, 8'h30 + 8'(i), 1, 1);
        add(1, 8'h35, 1, 1, 1, 8'h25, 1);
        // 23..28: target 3 command into a full queue -> dropped
        add(0, 8'h60, 1, 1);
        for (int i = 1; i <= 4; i++) add(1, 8'h40 + 8'(i), 1, 1);
        add(1, 8'h45, 1, 0);
        // 29..45: ICD opcode 0x88 (16 bytes) exceeds 12 -> absorbed silently
        add(0, 8'h9F, 0, 0);
        add(1, 8'h88, 1, 0);
        for (int i = 1; i <= 15; i++) add(1, 8'(i), 1, 0);
        // 46..51: disabled target 2
        add(0, 8'h40, 1, 0);
        for (int i = 1; i <= 5; i++) add(1, 8'h60 + 8'(i), 1, 0);
        // 52..57: fresh command after a timeout
        add(0, 8'h23, 1, 1);
        for (int i = 1; i <= 4; i++) add(1, 8'h50 + 8'(i), 1, 1);
        add(1, 8'h55, 1, 0, 1, 8'h25);

        repeat (3) @(posedge clk);
        #1;
        check("reset irq", 8'(irq), 8'h00);
        check("reset busy", 8'(busy), 8'h00);
        rd(5'd17, r); check("reset qstat", r, 8'h00);
        check("cpu_dout", cpu_dout, 8'hA5);
        status_sel = 5'd0;
        @(negedge clk);
        reset = 1'b0;

        apply(0, 17);
        check("busy two cmds", 8'(busy), 8'h01);
        rd(5'd17, r); check("qstat two cmds", r, 8'h21);
        rd(5'd18, r); check("sel 18", r, 8'h00);
        status_sel = 5'd0;

        apply(17, 23);
        rd(5'd17, r); check("qstat push+pop", r, 8'h21);
        apply(23, 29);
        rd(5'd17, r); check("qstat overflow", r, 8'h23);
        status_sel = 5'd0;

        drain(1'b0, 1'b0);
        drain(1'b1, 1'b1);

        @(negedge clk);
        cpu_sel = 1'b1; cpu_rw = 1'b1; dma_status = 8'h3C;
        @(posedge clk);
        #1;
        cpu_sel = 1'b0; cpu_rw = 1'b0;
        check("read clears irq", 8'(irq), 8'h00);
        check("cpu_dout follows", cpu_dout, 8'h3C);

        @(negedge clk);
        status_sel = 5'd17; dma_nak = 1'b1;
        @(posedge clk);
        #1;
        dma_nak = 1'b0;
        rd(5'd17, r); check("overflow cleared", r, 8'h00);
        status_sel = 5'd0;

        apply(29, 52);
        check("busy after reject/disabled", 8'(busy), 8'h00);
        rd(5'd17, r); check("qstat after reject", r, 8'h00);
        status_sel = 5'd0;

        wr(0, 8'h20); check("tmo irq b0", 8'(irq), 8'h01);
        wr(1, 8'h01); check("tmo irq b1", 8'(irq), 8'h01);
        wr(1, 8'h02); check("tmo irq b2", 8'(irq), 8'h01);
        repeat (TMO + 5) @(posedge clk);
        #1;
        wr(1, 8'h03); check("post-timeout byte irq", 8'(irq), 8'h00);
        check("post-timeout busy", 8'(busy), 8'h00);
        rd(5'd17, r); check("qstat timeout", r, 8'h04);
        status_sel = 5'd0;

        apply(52, 58);
        rd(5'd17, r); check("qstat new cmd", r, 8'h15);
        status_sel = 5'd0;
        drain(1'b1, 1'b1);

        wr(0, 8'h20); check("pre-reset irq", 8'(irq), 8'h01);
        #1 reset = 1'b1;
        #1;
        check("async reset irq", 8'(irq), 8'h00);
        rd(5'd17, r); check("reset qstat", r, 8'h00);
        status_sel = 5'd0;
        @(negedge clk);
        reset = 1'b0;
        wr(1, 8'h01); check("idle follow byte", 8'(irq), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
